// File: rtl/backscatter_frame_scheduler.sv
// Round-robin payload arbiter and trigger sequencer for the tag's bit-serial frame source.
// Each grant gives a setup window, one triggered frame of FRAME_BITS*BIT_PERIOD cycles, then a gap.
module backscatter_frame_scheduler #(
  parameter int BIT_PERIOD   = 50,
  parameter int FRAME_BITS   = 144,
  parameter int SETUP_CYCLES = 3,
  parameter int GAP_CYCLES   = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        abort,
  input  logic        req0_valid,
  input  logic [9:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [9:0]  req1_data,
  output logic        req1_ready,
  output logic [9:0]  payload,
  output logic        trigger,
  output logic        busy,
  output logic        grant_id,
  output logic        frame_done,
  output logic        aborted,
  output logic [15:0] frames_sent
);

  localparam int CNT_MAX = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PH_W    = $clog2(BIT_PERIOD + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SEND, GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [9:0]         payload_q, payload_d;
  logic               grant_id_q, grant_id_d;
  logic               rr_q, rr_d;
  logic [15:0]        frames_sent_q, frames_sent_d;
  logic               trigger_q, trigger_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               aborted_q, aborted_d;
  logic               win;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    phase_d       = phase_q;
    bit_d         = bit_q;
    payload_d     = payload_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    frames_sent_d = frames_sent_q;
    frame_done_d  = 1'b0;
    aborted_d     = 1'b0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    win           = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (req0_valid || req1_valid)) begin
          // rr only matters when both requesters are valid
          win        = req1_valid && (!req0_valid || rr_q);
          req0_ready = !win;
          req1_ready = win;
          payload_d  = win ? req1_data : req0_data;
          grant_id_d = win;
          rr_d       = !win;
          cnt_d      = CNT_W'(SETUP_CYCLES - 1);
          state_d    = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          aborted_d = 1'b1;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else if (cnt_q == '0) begin
          phase_d = '0;
          bit_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SEND: begin
        // abort takes priority even on the final bit-phase cycle
        if (abort) begin
          aborted_d = 1'b1;
          cnt_d     = CNT_W'(GAP_CYCLES - 1);
          state_d   = GAP;
        end else if (phase_q == PH_W'(BIT_PERIOD - 1)) begin
          phase_d = '0;
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            bit_d         = '0;
            frame_done_d  = 1'b1;
            frames_sent_d = frames_sent_q + 16'd1;
            cnt_d         = CNT_W'(GAP_CYCLES - 1);
            state_d       = GAP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    trigger_d = (state_d == SEND);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      bit_q         <= '0;
      payload_q     <= '0;
      grant_id_q    <= 1'b0;
      rr_q          <= 1'b0;
      frames_sent_q <= '0;
      trigger_q     <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      payload_q     <= payload_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
      frames_sent_q <= frames_sent_d;
      trigger_q     <= trigger_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign payload     = payload_q;
  assign trigger     = trigger_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign frame_done  = frame_done_q;
  assign aborted     = aborted_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_backscatter_frame_scheduler.sv
// Bench for backscatter_frame_scheduler: directed scenarios with random payload data, checked
// every cycle against a timeline model built from grant/abort cycle arithmetic.
module tb_backscatter_frame_scheduler;

  localparam int BP = 50;
  localparam int FB = 144;
  localparam int S  = 3;
  localparam int G  = 100;
  localparam int F  = BP * FB;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        abort = 1'b0;
  logic        req0_valid = 1'b0;
  logic [9:0]  req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [9:0]  req1_data = '0;
  logic        req1_ready;
  logic [9:0]  payload;
  logic        trigger;
  logic        busy;
  logic        grant_id;
  logic        frame_done;
  logic        aborted;
  logic [15:0] frames_sent;

  backscatter_frame_scheduler dut (
    .clock(clock), .reset(reset), .enable(enable), .abort(abort),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .payload(payload), .trigger(trigger), .busy(busy), .grant_id(grant_id),
    .frame_done(frame_done), .aborted(aborted), .frames_sent(frames_sent)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference timeline: a frame granted in cycle g owns setup g+1..g+S, send g+S+1..end_send,
  // gap end_send+1..end_send+G; an abort in cycle a moves end_send to a.
  int          cyc = 0;
  bit          active = 1'b0;
  int          g = 0;
  int          end_send = 0;
  bit          ab = 1'b0;
  bit          m_rr = 1'b0;
  logic [15:0] m_frames = '0;
  logic [9:0]  m_payload = '0;
  bit          m_gid = 1'b0;
  bit          rand_data = 1'b1;
  int          grant_ids[$];
  int          grant_cycs[$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    active    = 1'b0;
    ab        = 1'b0;
    m_rr      = 1'b0;
    m_frames  = '0;
    m_payload = '0;
    m_gid     = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    bit idle, w, exp_r0, exp_r1, e_trig, e_busy, e_done, e_ab;
    if (rand_data) begin
      req0_data = 10'($urandom);
      req1_data = 10'($urandom);
    end
    #1;
    idle   = !active || (cyc > end_send + G);
    w      = 1'b0;
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (idle && enable && (req0_valid || req1_valid)) begin
      w      = req1_valid && (!req0_valid || m_rr);
      exp_r0 = !w;
      exp_r1 = w;
    end
    chk("req0_ready", 16'(req0_ready), 16'(exp_r0));
    chk("req1_ready", 16'(req1_ready), 16'(exp_r1));
    if (exp_r0 || exp_r1) begin
      active    = 1'b1;
      g         = cyc;
      end_send  = cyc + S + F;
      ab        = 1'b0;
      m_payload = w ? req1_data : req0_data;
      m_gid     = w;
      m_rr      = !w;
      grant_ids.push_back(int'(w));
      grant_cycs.push_back(cyc);
    end else if (abort && active && cyc >= g + 1 && cyc <= end_send) begin
      ab       = 1'b1;
      end_send = cyc;
    end
    @(posedge clock);
    cyc++;
    #1;
    e_trig = active && cyc >= g + S + 1 && cyc <= end_send;
    e_busy = active && cyc >= g + 1 && cyc <= end_send + G;
    e_done = active && !ab && cyc == end_send + 1;
    e_ab   = active && ab && cyc == end_send + 1;
    if (e_done) m_frames = m_frames + 16'd1;
    chk("trigger",     16'(trigger),    16'(e_trig));
    chk("busy",        16'(busy),       16'(e_busy));
    chk("frame_done",  16'(frame_done), 16'(e_done));
    chk("aborted",     16'(aborted),    16'(e_ab));
    chk("frames_sent", frames_sent,     m_frames);
    chk("payload",     16'(payload),    16'(m_payload));
    chk("grant_id",    16'(grant_id),   16'(m_gid));
    @(negedge clock);
  endtask

  task automatic run_idle();
    while (active && cyc <= end_send + G) tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_trigger"},     16'(trigger),    16'h0);
    chk({tag, "_busy"},        16'(busy),       16'h0);
    chk({tag, "_payload"},     16'(payload),    16'h0);
    chk({tag, "_grant_id"},    16'(grant_id),   16'h0);
    chk({tag, "_frame_done"},  16'(frame_done), 16'h0);
    chk({tag, "_aborted"},     16'(aborted),    16'h0);
    chk({tag, "_frames_sent"}, frames_sent,     16'h0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_reset_values("rst");
    model_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic [15:0] saved;
    #1 reset = 1'b0;
    #1;
    check_reset_values("por");
    @(negedge clock);
    reset = 1'b1;

    // single request
    rand_data  = 1'b0;
    req0_data  = 10'h2A5;
    enable     = 1'b1;
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    chk("single_payload", 16'(payload), 16'h2A5);
    run_idle();
    chk("single_frames", frames_sent, 16'd1);

    // contention from reset
    pulse_reset();
    grant_ids.delete();
    grant_cycs.delete();
    req0_data  = 10'h001;
    req1_data  = 10'h3FF;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    while (grant_ids.size() < 4 && cyc < 40000) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_idle();
    chk("contention_grants", 16'(grant_ids.size()), 16'd4);
    for (int i = 0; i < grant_ids.size(); i++) begin
      chk("contention_order", 16'(grant_ids[i]), 16'(i % 2));
      if (i > 0) chk("contention_spacing", 16'(grant_cycs[i] - grant_cycs[i-1]), 16'(1 + S + F + G));
    end
    chk("contention_frames", frames_sent, 16'd4);

    // abort at SEND cycle 1000, then confirm rr moved past the aborted requester
    rand_data  = 1'b1;
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    saved = frames_sent;
    while (cyc < g + S + 1000) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_trigger_low", 16'(trigger), 16'h0);
    run_idle();
    chk("abort_frames", frames_sent, saved);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("abort_rr_next", 16'(grant_id), 16'h0);

    // abort coinciding with the last SEND cycle
    saved = frames_sent;
    while (cyc < g + S + F) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run_idle();
    chk("abort_last_frames", frames_sent, saved);

    // enable gating, and dropping enable mid-SEND
    enable     = 1'b0;
    req1_valid = 1'b1;
    repeat (5) tick();
    enable = 1'b1;
    tick();
    req1_valid = 1'b0;
    saved = frames_sent;
    while (cyc < g + S + 10) tick();
    enable = 1'b0;
    run_idle();
    chk("enable_drop_frames", frames_sent, saved + 16'd1);
    enable = 1'b1;

    // reset mid-SEND, then a fresh full frame
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    while (cyc < g + S + 3000) tick();
    chk("pre_reset_trigger", 16'(trigger), 16'h1);
    pulse_reset();
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    run_idle();
    chk("post_reset_frames", frames_sent, 16'd1);

    // frames_sent wrap
    force dut.frames_sent_q = 16'hFFFF;
    #1;
    release dut.frames_sent_q;
    m_frames = 16'hFFFF;
    chk("wrap_preload", frames_sent, 16'hFFFF);
    req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    run_idle();
    chk("wrap_frames", frames_sent, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
